// File: rtl/reg_file24.sv
// Eight-entry register file with R0 hardwired to zero, plus a registered ALU flag triple; optional write-through via REGFILE_BYPASS_EN.
// Reads are combinational, writes and flag loads take effect on the rising edge; there is no backpressure, every request is accepted.
`timescale 1ns/1ps
module reg_file24 #(
    parameter int DATA_WIDTH = 24,
    parameter int ADDR_WIDTH = 3
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic [ADDR_WIDTH-1:0] i_read_reg1,
    input  logic [ADDR_WIDTH-1:0] i_read_reg2,
    input  logic [ADDR_WIDTH-1:0] i_write_reg,
    input  logic [DATA_WIDTH-1:0] i_write_data,
    input  logic                  i_reg_write,
    input  logic                  i_flag_write,
    input  logic                  i_alu_zero,
    input  logic                  i_alu_overflow,
    input  logic                  i_alu_cout,
    output logic [DATA_WIDTH-1:0] o_read_data1,
    output logic [DATA_WIDTH-1:0] o_read_data2,
    output logic                  o_flag_zero,
    output logic                  o_flag_overflow,
    output logic                  o_flag_carry
);

    localparam int NUM_REGS = 1 << ADDR_WIDTH;

    // R0 has no storage; it is synthesised as a constant zero on the read side.
    logic [DATA_WIDTH-1:0] r_regs [1:NUM_REGS-1];
    logic                  r_flag_zero;
    logic                  r_flag_overflow;
    logic                  r_flag_carry;

    logic                  w_wr_en;
    logic [DATA_WIDTH-1:0] w_rd1;
    logic [DATA_WIDTH-1:0] w_rd2;

    assign w_wr_en = i_reg_write && (i_write_reg != '0);

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            for (int i = 1; i < NUM_REGS; i++) begin
                r_regs[i] <= '0;
            end
            r_flag_zero     <= 1'b0;
            r_flag_overflow <= 1'b0;
            r_flag_carry    <= 1'b0;
        end else begin
            if (w_wr_en) begin
                r_regs[i_write_reg] <= i_write_data;
            end
            if (i_flag_write) begin
                r_flag_zero     <= i_alu_zero;
                r_flag_overflow <= i_alu_overflow;
                r_flag_carry    <= i_alu_cout;
            end
        end
    end

    always_comb begin
        w_rd1 = '0;
        w_rd2 = '0;
        if (i_read_reg1 != '0) begin
`ifdef REGFILE_BYPASS_EN
            w_rd1 = (w_wr_en && (i_read_reg1 == i_write_reg)) ? i_write_data : r_regs[i_read_reg1];
`else
            w_rd1 = r_regs[i_read_reg1];
`endif
        end
        if (i_read_reg2 != '0) begin
`ifdef REGFILE_BYPASS_EN
            w_rd2 = (w_wr_en && (i_read_reg2 == i_write_reg)) ? i_write_data : r_regs[i_read_reg2];
`else
            w_rd2 = r_regs[i_read_reg2];
`endif
        end
    end

    assign o_read_data1    = w_rd1;
    assign o_read_data2    = w_rd2;
    assign o_flag_zero     = r_flag_zero;
    assign o_flag_overflow = r_flag_overflow;
    assign o_flag_carry    = r_flag_carry;

endmodule

// File: tb/tb_reg_file24.sv
// Randomised and directed bench for reg_file24: a queue-based scoreboard fed by the stimulus,
// drained by an independent monitor that samples outputs mid-cycle.
`timescale 1ns/1ps
module tb_reg_file24;

    logic        clk;
    logic        rst_n;
    logic [2:0]  rr1, rr2, wr;
    logic [23:0] wd;
    logic        we, fw, az, ao, ac;
    logic [23:0] rd1, rd2;
    logic        fz, fo, fc;

    reg_file24 #(.DATA_WIDTH(24), .ADDR_WIDTH(3)) dut (
        .i_clk          (clk),
        .i_rst_n        (rst_n),
        .i_read_reg1    (rr1),
        .i_read_reg2    (rr2),
        .i_write_reg    (wr),
        .i_write_data   (wd),
        .i_reg_write    (we),
        .i_flag_write   (fw),
        .i_alu_zero     (az),
        .i_alu_overflow (ao),
        .i_alu_cout     (ac),
        .o_read_data1   (rd1),
        .o_read_data2   (rd2),
        .o_flag_zero    (fz),
        .o_flag_overflow(fo),
        .o_flag_carry   (fc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [23:0] rd1;
        logic [23:0] rd2;
        logic [2:0]  fl;
    } exp_t;

    exp_t  q[$];
    string qn[$];
    int    errors = 0;
    int    checks = 0;

    // Reference state: plain array of register values and a flag vector.
    logic [23:0] m_reg [8];
    logic [2:0]  m_fl;

    function automatic logic [23:0] m_read(input logic [2:0] a, input logic w_en,
                                           input logic [2:0] w_a, input logic [23:0] w_d);
        if (a == 3'd0) return 24'd0;
`ifdef REGFILE_BYPASS_EN
        if (w_en && (w_a == a)) return w_d;
`endif
        return m_reg[a];
    endfunction

    task automatic cyc(input logic r_n, input logic w_en, input logic f_en,
                       input logic [2:0] a1, input logic [2:0] a2, input logic [2:0] w_a,
                       input logic [23:0] w_d, input logic z, input logic o, input logic c,
                       input string nm);
        exp_t e;
        @(negedge clk);
        rst_n = r_n; we = w_en; fw = f_en; rr1 = a1; rr2 = a2; wr = w_a; wd = w_d;
        az = z; ao = o; ac = c;
        e.rd1 = m_read(a1, w_en, w_a, w_d);
        e.rd2 = m_read(a2, w_en, w_a, w_d);
        e.fl  = m_fl;
        q.push_back(e);
        qn.push_back(nm);
        if (!r_n) begin
            for (int i = 0; i < 8; i++) m_reg[i] = 24'd0;
            m_fl = 3'b000;
        end else begin
            if (w_en && w_a != 3'd0) m_reg[w_a] = w_d;
            if (f_en) m_fl = {z, o, c};
        end
    endtask

    // Monitor: pops one expectation per cycle, 3ns after the falling edge.
    initial begin
        exp_t  e;
        string n;
        forever begin
            @(negedge clk);
            #3;
            if (q.size() > 0) begin
                e = q.pop_front();
                n = qn.pop_front();
                checks++;
                if (rd1 !== e.rd1) begin
                    errors++;
                    $display("FAIL %s read_data1: got %h expected %h", n, rd1, e.rd1);
                end
                checks++;
                if (rd2 !== e.rd2) begin
                    errors++;
                    $display("FAIL %s read_data2: got %h expected %h", n, rd2, e.rd2);
                end
                checks++;
                if ({fz, fo, fc} !== e.fl) begin
                    errors++;
                    $display("FAIL %s flags(z,o,c): got %b expected %b", n, {fz, fo, fc}, e.fl);
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "timeout");
    end

    initial begin
        logic [2:0]  a1, a2, w_a;
        logic [23:0] w_d;
        rst_n = 1'b0; we = 1'b0; fw = 1'b0; rr1 = '0; rr2 = '0; wr = '0; wd = '0;
        az = 1'b0; ao = 1'b0; ac = 1'b0;
        for (int i = 0; i < 8; i++) m_reg[i] = 24'd0;
        m_fl = 3'b000;
        @(posedge clk);

        for (int a = 0; a < 8; a++)
            cyc(1, 0, 0, 3'(a), 3'(7 - a), 0, 24'd0, 0, 0, 0, "reset_read");

        cyc(1, 1, 0, 0, 0, 3, 24'hABCDEF, 0, 0, 0, "write_r3");
        cyc(1, 1, 0, 0, 0, 5, 24'h000001, 0, 0, 0, "write_r5");
        cyc(1, 0, 0, 3, 5, 0, 24'd0, 0, 0, 0, "read_r3_r5");

        cyc(1, 1, 0, 0, 0, 0, 24'hFFFFFF, 0, 0, 0, "write_r0");
        cyc(1, 0, 0, 0, 0, 0, 24'd0, 0, 0, 0, "read_r0");

        cyc(1, 1, 0, 2, 0, 2, 24'h123456, 0, 0, 0, "bypass_pre_edge");
        cyc(1, 0, 0, 2, 2, 0, 24'd0, 0, 0, 0, "bypass_post_edge");

        cyc(1, 0, 1, 0, 0, 0, 24'd0, 1, 0, 1, "flag_load");
        cyc(1, 0, 0, 0, 0, 0, 24'd0, 0, 1, 0, "flag_hold");
        cyc(1, 0, 0, 0, 0, 0, 24'd0, 0, 1, 0, "flag_held");

        cyc(0, 1, 1, 4, 3, 4, 24'h00FF00, 1, 1, 1, "reset_priority");
        cyc(1, 0, 0, 4, 3, 0, 24'd0, 0, 0, 0, "reset_priority_after");
        cyc(1, 1, 0, 6, 0, 6, 24'h0A0B0C, 0, 0, 0, "first_write_after_reset");
        cyc(1, 1, 1, 6, 6, 1, 24'h777777, 1, 1, 0, "both_enables");
        cyc(1, 0, 0, 6, 1, 0, 24'd0, 0, 0, 0, "both_enables_after");

        for (int n = 0; n < 400; n++) begin
            w_a = 3'($urandom_range(0, 7));
            w_d = 24'($urandom);
            a1  = ($urandom_range(0, 3) == 0) ? w_a : 3'($urandom_range(0, 7));
            a2  = ($urandom_range(0, 3) == 0) ? a1  : 3'($urandom_range(0, 7));
            cyc(($urandom_range(0, 19) != 0), 1'($urandom), 1'($urandom), a1, a2, w_a, w_d,
                1'($urandom), 1'($urandom), 1'($urandom), "random");
        end

        repeat (3) @(negedge clk);
        #5;
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expectations left, expected 0", q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/reg_file24.md
REG_FILE24 -- requirements
Module: reg_file24

Interface
REQ-001 Parameters:
- DATA_WIDTH, 24: register and data bus width.
- ADDR_WIDTH, 3: register address width; 2**ADDR_WIDTH registers.

REQ-002 Ports:
- Clock  in  1  sole clock; all state updates on the rising edge.
- Reset  in  1  synchronous, active-low reset.
- ReadReg1  in  ADDR_WIDTH  address for read port 1, which feeds the ALU A operand.
- ReadReg2  in  ADDR_WIDTH  address for read port 2, which feeds the ALU B operand.
- WriteReg  in  ADDR_WIDTH  write-back destination address.
- WriteData  in  DATA_WIDTH  write-back value (ALU Result or load data).
- RegWrite  in  1  write enable for WriteReg.
- FlagWrite  in  1  capture enable for the ALU status flags.
- ALUZero  in  1  ALU zero output.
- ALUOverflow  in  1  ALU overflow output.
- ALUCout  in  1  ALU carry-out.
- ReadData1  out  DATA_WIDTH  contents of ReadReg1.
- ReadData2  out  DATA_WIDTH  contents of ReadReg2.
- FlagZero  out  1  registered zero flag.
- FlagOverflow  out  1  registered overflow flag.
- FlagCarry  out  1  registered carry flag.

Function
REQ-003 The block SHALL hold 2**ADDR_WIDTH registers of DATA_WIDTH bits, R0..R7 at default parameters.
REQ-004 R0 SHALL always read as 0, and any write to R0 SHALL be discarded.
REQ-005 Reads SHALL be combinational: ReadDataN reflects the current register contents with zero clock latency.
REQ-006 When RegWrite=1 and WriteReg!=0, WriteData SHALL be stored into WriteReg on the rising edge; the new value is visible on the read ports from that edge onward (1-cycle write latency).
REQ-007 When RegWrite=0, no register SHALL change.
REQ-008 When FlagWrite=1, FlagZero/FlagOverflow/FlagCarry SHALL load ALUZero/ALUOverflow/ALUCout on the rising edge; when FlagWrite=0 they SHALL hold.
REQ-009 RegWrite and FlagWrite SHALL be independent; both may be asserted in the same cycle with no interaction.
REQ-010 Both read ports SHALL be allowed to address the same register in the same cycle, and both SHALL return identical data.
REQ-011 Flags SHALL be registered only and never combinationally driven from the ALU inputs.

Reset
REQ-012 When Reset=0 at a rising edge, every register R1..R7 SHALL clear to 24'd0 and all three flags SHALL clear to 0.
REQ-013 Reset SHALL take priority over RegWrite and FlagWrite asserted in the same cycle.
REQ-014 After Reset returns to 1, the first write SHALL take effect on the next rising edge with RegWrite=1.

Configuration
REQ-015 Macro REGFILE_BYPASS_EN:
- Defined: when RegWrite=1, WriteReg!=0 and ReadRegN==WriteReg in the same cycle, ReadDataN SHALL return WriteData combinationally (write-through); R0 is never bypassed.
- Undefined: ReadDataN SHALL return the pre-write stored value until the clock edge.

Verification
REQ-016 Reset=0 for 1 edge, then read all addresses -> every ReadData=0 and all flags=0.
REQ-017 Write R3=24'hABCDEF and R5=24'h000001, then ReadReg1=3 and ReadReg2=5 -> ReadData1=24'hABCDEF and ReadData2=24'h000001.
REQ-018 Write R0=24'hFFFFFF, then read R0 on both ports -> ReadData=0.
REQ-019 RegWrite=1, WriteReg=2, WriteData=24'h123456, ReadReg1=2, with prior R2=0, sampled before the edge -> ReadData1=24'h123456 with REGFILE_BYPASS_EN defined, 0 without it; 24'h123456 after the edge in both builds.
REQ-020 FlagWrite=1 with ALUZero=1, ALUOverflow=0, ALUCout=1, then FlagWrite=0 with the inputs inverted -> flags stay 1/0/1.
REQ-021 R4=24'h00FF00 with RegWrite=1 and Reset=0 in the same cycle -> R4 reads 0 afterward.
